decoder3to8_pipe: RTL and testbench

Streaming 3-to-8 one-hot decoder: the receive-side counterpart of the 8-to-3 encoder. It accepts a 3-bit code over a valid/ready handshake and presents the matching one-hot byte on a registered valid/ready output. A two-entry skid buffer sustains one transfer per cycle under backpressure. Optional per-code occurrence counters support link statistics.

---
 rtl/dec_pkg.sv | 27 ++
 rtl/decoder3to8_skid.sv | 98 +++++++++
 rtl/decoder3to8_pipe.sv | 88 ++++++++
 tb/tb_decoder3to8_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// ---------------------------------------------------------------------------
// dec_pkg
// Shared constants for the streaming 3-to-8 decoder:
//   - widths of the code, the one-hot byte and the occurrence counters
//   - skid buffer state encoding (EMPTY / ONE / FULL)
//   - decode_onehot(): binary code -> one-hot byte, bit `code` set
// Optional counters in the top level are built only when DEC_COUNT_EN is
// defined.
// ---------------------------------------------------------------------------
package dec_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;
    localparam int CNT_W    = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    // Skid buffer occupancy states.
    localparam logic [1:0] EMPTY = 2'd0;  // nothing held
    localparam logic [1:0] ONE   = 2'd1;  // main register valid
    localparam logic [1:0] FULL  = 2'd2;  // main and skid both valid

    function automatic logic [ONEHOT_W-1:0] decode_onehot(input logic [CODE_W-1:0] code);
        return ONEHOT_W'(1) << code;
    endfunction

endpackage

// File: rtl/decoder3to8_skid.sv
// ---------------------------------------------------------------------------
// decoder3to8_skid
// Two-entry valid/ready skid buffer. The main register drives the output;
// the skid register absorbs one extra item so the upstream side can run at
// one transfer per cycle without in_ready looking at out_ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_data/in_valid    upstream payload and valid
//   in_ready            buffer can accept (registered state only, and !rst)
//   out_data/out_valid  main register contents and valid
//   out_ready           downstream accepts out_data this cycle
// The main register is cleared to zero whenever the buffer drains.
// ---------------------------------------------------------------------------
module decoder3to8_skid
    import dec_pkg::*;
#(
    parameter int W = CODE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [1:0]   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;

    logic accept;
    logic deliver;

    assign in_ready  = !rst && (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (accept && deliver) begin
                    main_d = in_data;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (deliver) begin
                    state_d = EMPTY;
                    main_d  = '0;
                end
            end
            FULL: begin
                // in_ready is low here, so only a deliver can move us.
                if (deliver) begin
                    state_d = ONE;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/decoder3to8_pipe.sv
// ---------------------------------------------------------------------------
// decoder3to8_pipe
// Streaming 3-to-8 one-hot decoder with a valid/ready interface on both
// sides and a two-entry skid buffer for full throughput under backpressure.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_code/in_valid/in_ready    upstream binary code handshake
//   out/out_valid/out_ready      downstream one-hot byte handshake
//   cnt_sel, cnt_clr, cnt_val    per-code occurrence counter read/clear
// Build option DEC_COUNT_EN: when defined, eight saturating 8-bit counters
// count delivered codes; when undefined, cnt_sel/cnt_clr are ignored and
// cnt_val reads 8'h00.
// ---------------------------------------------------------------------------
module decoder3to8_pipe
    import dec_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [CODE_W-1:0]   in_code,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [ONEHOT_W-1:0] out,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic [CODE_W-1:0]   cnt_sel,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    cnt_val
);

    logic [CODE_W-1:0] main_code;

    decoder3to8_skid #(
        .W (CODE_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_code),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (main_code),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // A cleared main register holds code 0, which would decode to 8'h01;
    // gating with out_valid keeps out at 8'h00 while nothing is held.
    assign out = out_valid ? decode_onehot(main_code) : '0;

`ifdef DEC_COUNT_EN
    logic                 deliver;
    logic [CNT_W-1:0]     cnt_q [ONEHOT_W];
    logic [CNT_W-1:0]     cnt_d [ONEHOT_W];

    assign deliver = out_valid && out_ready;

    always_comb begin
        cnt_d = cnt_q;
        // Clear takes priority over a same-cycle increment.
        if (cnt_clr) begin
            for (int k = 0; k < ONEHOT_W; k++) begin
                cnt_d[k] = '0;
            end
        end else if (deliver && (cnt_q[main_code] != CNT_MAX)) begin
            cnt_d[main_code] = cnt_q[main_code] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: this small array is reset explicitly because the counts are
        // software-visible; bulk storage without that need would skip it.
        if (rst) begin
            for (int k = 0; k < ONEHOT_W; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_val = cnt_q[cnt_sel];
`else
    logic unused_cnt_inputs;

    assign unused_cnt_inputs = ^{cnt_sel, cnt_clr};
    assign cnt_val           = '0;
`endif

endmodule

// File: tb/tb_decoder3to8_pipe.sv
// ---------------------------------------------------------------------------
// tb_decoder3to8_pipe
// Scoreboard bench: the driver pushes the hand-computed one-hot byte when a
// code is accepted; a monitor pops and compares on every delivery.
// ---------------------------------------------------------------------------
module tb_decoder3to8_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_code;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] cnt_sel;
    logic       cnt_clr;
    logic [7:0] cnt_val;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] exp_q [$];

    // Hand-written decode table: code k -> bit k.
    logic [7:0] onehot_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                   8'h10, 8'h20, 8'h40, 8'h80};

    decoder3to8_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_code   (in_code),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt_sel   (cnt_sel),
        .cnt_clr   (cnt_clr),
        .cnt_val   (cnt_val)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Offer one code; push the expected byte once in_ready guarantees the
    // accept at the next rising edge. Returns 1 time unit after that edge.
    task automatic send(input logic [2:0] c, input logic [7:0] e);
        int guard;
        guard    = 0;
        in_code  = c;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 100) begin
                check("send_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        if (in_ready) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: a delivery happens at the next rising edge when both
    // out_valid and out_ready are high at the falling edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(out), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_order", 32'(out), 32'(e));
                    check("out_onehot", 32'($onehot(out)), 32'd1);
                end
            end
        end
    end

    initial begin
        int start;
        logic [2:0] c;
        bit done;

        rst       = 1'b1;
        in_code   = 3'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt_sel   = 3'd0;
        cnt_clr   = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'h00);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_cnt_val", 32'(cnt_val), 32'h00);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // ---- codes 0..7 back-to-back, 1-cycle latency, 1/cycle ----
        start = cyc;
        for (int i = 0; i < 8; i++) begin
            send(3'(i), onehot_tbl[i]);
            check("latency_valid", 32'(out_valid), 32'd1);
            check("latency_out", 32'(out), 32'(onehot_tbl[i]));
        end
        check("throughput_cycles", 32'(cyc - start), 32'd8);
        wait_drain();
        check("empty_out_zero", 32'(out), 32'h00);

        // ---- backpressure: 3 and 5 absorbed, 6 stalls ----
        out_ready = 1'b0;
        send(3'd3, 8'h08);
        send(3'd5, 8'h20);
        in_code  = 3'd6;
        in_valid = 1'b1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_out", 32'(out), 32'h08);
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        send(3'd6, 8'h40);
        wait_drain();

        // ---- reset while FULL ----
        out_ready = 1'b0;
        send(3'd1, 8'h02);
        send(3'd2, 8'h04);
        check("pre_rst_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out", 32'(out), 32'h00);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("postrst_in_ready", 32'(in_ready), 32'd1);
        check("postrst_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        // ---- toggling in_valid with random out_ready ----
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    c = 3'($urandom_range(0, 7));
                    send(c, onehot_tbl[c]);
                    in_code = 3'($urandom_range(0, 7));  // ignored while idle
                    @(posedge clk);
                    #1;
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

`ifdef DEC_COUNT_EN
        // ---- counters: clear, count, saturate, clear beats increment ----
        cnt_sel = 3'd2;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("cnt_cleared", 32'(cnt_val), 32'd0);
        for (int i = 0; i < 5; i++) send(3'd2, 8'h04);
        wait_drain();
        check("cnt_five", 32'(cnt_val), 32'd5);
        for (int i = 0; i < 295; i++) send(3'd2, 8'h04);
        wait_drain();
        check("cnt_saturate", 32'(cnt_val), 32'd255);
        cnt_sel = 3'd7;
        #1;
        check("cnt_other_code", 32'(cnt_val), 32'd0);
        cnt_sel = 3'd2;
        cnt_clr = 1'b1;
        send(3'd2, 8'h04);
        @(posedge clk);  // deliver edge, clear still high
        #1;
        cnt_clr = 1'b0;
        wait_drain();
        check("cnt_clr_wins", 32'(cnt_val), 32'd0);
`else
        // ---- counters absent: cnt_val stays zero ----
        for (int i = 0; i < 8; i++) send(3'(i), onehot_tbl[i]);
        wait_drain();
        for (int i = 0; i < 8; i += 3) begin
            cnt_sel = 3'(i);
            cnt_clr = 1'(i & 1);
            #1;
            check("cnt_tied_zero", 32'(cnt_val), 32'h00);
        end
        cnt_clr = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
